// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
package pipe_adder_pkg;

  // Operation select carried on the sub input
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // True when the operand width splits into whole chunks
  function automatic bit chunk_fits(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB
// so the last slice can derive signed overflow.
module add_chunk
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] total;

  // Widened add; the carry into the MSB is recovered from a ^ b ^ s at that bit
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    s     = total[CHUNK-1:0];
    co    = total[CHUNK];
    cmsb  = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each stage adds one CHUNK of the
// operands using the carry registered by the stage before it, with a
// valid/ready handshake per stage so bubbles collapse under back-pressure.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
    $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Stage inputs: index 0 is fed from the ports, index k from stage k-1
  logic [WIDTH-1:0]  xa [STAGES];
  logic [WIDTH-1:0]  xb [STAGES];
  logic [WIDTH-1:0]  xs [STAGES];
  logic [STAGES-1:0] xc;
  logic [STAGES-1:0] xv;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;

  // Subtract is A + ~B + 1, so cin is replaced by 1 in that mode
  assign xa[0]    = a;
  assign xb[0]    = (sub == SUB) ? ~b : b;
  assign xc[0]    = (sub == SUB) ? 1'b1 : cin;
  assign xs[0]    = '0;
  assign xv[0]    = in_valid;
  assign in_ready = rdy[0];

  // Ready ripples back from the output: a stage may load if empty or if the next one moves
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !vld[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] ch_s;
    logic             ch_co;
    logic             ch_cmsb;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;

    add_chunk #(.CHUNK(CHUNK)) u_add (
      .a    (xa[k][k*CHUNK +: CHUNK]),
      .b    (xb[k][k*CHUNK +: CHUNK]),
      .ci   (xc[k]),
      .s    (ch_s),
      .co   (ch_co),
      .cmsb (ch_cmsb)
    );

    assign vld[k] = vld_q;

    // Load a new partial sum when this stage is ready, otherwise hold
    always_comb begin
      vld_d = vld_q;
      s_d   = s_q;
      c_d   = c_q;
      if (rdy[k]) begin
        vld_d                   = xv[k];
        s_d                     = xs[k];
        s_d[k*CHUNK +: CHUNK]   = ch_s;
        c_d                     = ch_co;
      end
    end

    // Valid bit is the only state that needs clearing on reset
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= vld_d;
    end

    // Partial sum and carry registers
    always_ff @(posedge clk) begin
      s_q <= s_d;
      c_q <= c_d;
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q, a_d;
      logic [WIDTH-1:0] b_q, b_d;
      logic             cmsb_unused;

      // Carry the operand bits still to be consumed by later stages
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (rdy[k]) begin
          a_d = xa[k];
          b_d = xb[k];
        end
      end

      // Operand forwarding registers
      always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
      end

      assign xa[k+1]     = a_q;
      assign xb[k+1]     = b_q;
      assign xs[k+1]     = s_q;
      assign xc[k+1]     = c_q;
      assign xv[k+1]     = vld_q;
      assign cmsb_unused = ch_cmsb;
    end else begin : g_last
      logic               ov_q, ov_d;
      logic [2*WIDTH-1:0] ops_unused;

      // Signed overflow: carry into the MSB disagrees with the carry out
      always_comb begin
        ov_d = ov_q;
        if (rdy[k]) ov_d = ch_cmsb ^ ch_co;
      end

      // Overflow register
      always_ff @(posedge clk) begin
        ov_q <= ov_d;
      end

      assign ops_unused = {xa[k], xb[k]};

      // Data registers are not reset, so gate them until a result is present
      assign out_valid = vld_q;
      assign sum       = vld_q ? s_q : '0;
      assign cout      = vld_q & c_q;
      assign ovf       = vld_q & ov_q;
    end
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8, bits summed per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, and elaboration SHALL fail otherwise.
REQ-003 Derived constant STAGES = WIDTH/CHUNK, the pipeline depth; it SHALL NOT be overridable.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-high; the ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  operand set present on a, b, cin and sub.
REQ-008 in_ready  output  1  block accepts an operand set this cycle.
REQ-009 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-010 b  input  WIDTH  operand B.
REQ-011 cin  input  1  carry-in; used in add mode only.
REQ-012 sub  input  1  0 = A+B+cin; 1 = A-B.
REQ-013 out_valid  output  1  result present on sum, cout and ovf.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-016 cout  output  1  carry out of bit WIDTH-1; in subtract mode, 1 = no borrow.
REQ-017 ovf  output  1  signed two's-complement overflow.

Function
REQ-018 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-019 Subtract SHALL be computed as A + ~B + 1, and cin SHALL be ignored when sub=1.
REQ-020 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1; stage 0 uses the effective carry-in from REQ-019.
REQ-021 Each stage SHALL forward, in registers, the lower sum bits already computed, the unconsumed operand bits, the carry, and its valid bit.
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 when out_ready stays 1.
REQ-023 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-024 Stage k SHALL be ready when it is empty or when stage k+1 is ready; the last stage SHALL be ready when it is empty or out_ready=1; in_ready SHALL equal stage 0 ready.
REQ-025 Bubbles SHALL collapse: an empty stage SHALL accept data even while downstream stalls.
REQ-026 Stalled stages SHALL hold their contents unchanged; results SHALL leave in acceptance order, with no loss and no duplication.
REQ-027 out_valid, sum, cout and ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 ovf SHALL be 1 when the carry into the MSB differs from cout.
REQ-029 A simultaneous input and output transfer on a full pipeline SHALL succeed in the same cycle.

Reset
REQ-030 While rst=1, all stage valid bits SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1; sum, cout and ovf SHALL be 0.
REQ-031 Asserting rst mid-operation SHALL discard all in-flight operations with no output for them.
REQ-032 Datapath registers other than valid bits SHALL NOT require a reset, but outputs SHALL read 0 until the first valid result.

Structure
REQ-033 A shared package pipe_adder_pkg SHALL hold the mode encoding constants (ADD=0, SUB=1) and the WIDTH % CHUNK legality check function.
REQ-034 One sub-module, add_chunk, SHALL be a combinational CHUNK-bit adder with ports a, b, ci, s, co and cmsb (carry into MSB).
REQ-035 The stage registers and handshake logic SHALL live in pipe_adder, built with a generate loop over STAGES.

Verification (WIDTH=32, CHUNK=8)
REQ-036 Assert rst for 3 cycles, then release -> out_valid=0, in_ready=1, sum=0 throughout.
REQ-037 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0, with out_valid exactly 4 cycles after the transfer.
REQ-038 a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1; then a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-039 Send 10 back-to-back random operations while out_ready follows the pattern 1,0,0,1,... -> all 10 results match the reference model in order; in_ready=0 only when all 4 stages are full and out_ready=0.
REQ-040 Fill the pipeline, hold out_ready=0 for 5 cycles -> outputs stable; then with out_ready=1 and in_valid=1 -> one input and one output transfer per cycle.
REQ-041 Assert rst with 3 operations in flight -> none of them appears at the output; the first operation sent after reset emerges after 4 cycles with the correct value.
